// File: rtl/prefetch_queue_unit.sv
// Instruction prefetch queue: byte FIFO fed by code-fetch bus cycles at the PFP,
// drained by the execution unit, flushed and redirected on branch.
module prefetch_queue_unit #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    ce,
    input  logic                    pfp_set,
    input  logic [PC_W-1:0]         pfp_value,
    input  logic [1:0]              pop,
    output logic [7:0]              q_byte0,
    output logic [7:0]              q_byte1,
    output logic [$clog2(DEPTH):0]  q_len,
    output logic [PC_W-1:0]         q_head,
    output logic                    underflow,
    output logic                    fetch_req,
    output logic [PC_W-1:0]         fetch_addr,
    input  logic                    fetch_ack,
    input  logic                    fetch_done,
    input  logic [DATA_W-1:0]       fetch_din,
    input  logic                    fetch_bs16
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            fetch_req_q, fetch_req_d;
    logic            discard_q, discard_d;
    logic            underflow_q, underflow_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PC_W-1:0] head_q, head_d;
    logic [PC_W-1:0] pfp_q, pfp_d;
    logic [7:0]      mem_q [DEPTH];

    logic [PW-1:0]   len;
    logic [PW-1:0]   free;
    logic [PW-1:0]   pop_ext;
    logic [AW-1:0]   rd_idx0, rd_idx1;
    logic [AW-1:0]   wr_idx0, wr_idx1;
    logic [15:0]     din16;
    logic [1:0]      fill_cnt;
    logic [7:0]      fill_b0, fill_b1;
    logic            do_fill;
    logic            we0, we1;

    assign len     = wr_q - rd_q;
    assign free    = PW'(DEPTH) - len;
    assign pop_ext = PW'(pop);
    assign rd_idx0 = rd_q[AW-1:0];
    assign rd_idx1 = rd_q[AW-1:0] + AW'(1);
    assign wr_idx0 = wr_q[AW-1:0];
    assign wr_idx1 = wr_q[AW-1:0] + AW'(1);
    assign din16   = 16'(fetch_din);

    assign q_byte0    = mem_q[rd_idx0];
    assign q_byte1    = mem_q[rd_idx1];
    assign q_len      = len;
    assign q_head     = head_q;
    assign underflow  = underflow_q;
    assign fetch_req  = fetch_req_q;
    assign fetch_addr = pfp_q;

    // Dynamic bus sizing: an odd PFP on a 16-bit device lands on the high lane.
    always_comb begin
        fill_cnt = 2'd1;
        fill_b0  = din16[7:0];
        fill_b1  = din16[15:8];
        if (DATA_W == 16 && fetch_bs16) begin
            if (!pfp_q[0]) begin
                fill_cnt = 2'd2;
            end else begin
                fill_b0 = din16[15:8];
            end
        end
    end

    assign do_fill = ce && (state_q == WAIT) && fetch_done && !discard_q && !pfp_set;
    assign we0     = do_fill;
    assign we1     = do_fill && (fill_cnt == 2'd2);

    always_comb begin
        rd_d        = rd_q;
        wr_d        = wr_q;
        head_d      = head_q;
        pfp_d       = pfp_q;
        underflow_d = underflow_q;
        if (ce) begin
            underflow_d = 1'b0;
            if (pfp_set) begin
                rd_d   = '0;
                wr_d   = '0;
                head_d = pfp_value;
                pfp_d  = pfp_value;
            end else begin
                if (pop_ext > len) begin
                    underflow_d = 1'b1;
                end else begin
                    rd_d   = rd_q + pop_ext;
                    head_d = head_q + PC_W'(pop);
                end
                if (do_fill) begin
                    wr_d  = wr_q + PW'(fill_cnt);
                    pfp_d = pfp_q + PC_W'(fill_cnt);
                end
            end
        end
    end

    // Issue only with room for a full bus word, so an in-flight fetch always fits.
    always_comb begin
        state_d     = state_q;
        fetch_req_d = fetch_req_q;
        discard_d   = discard_q;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (!pfp_set && free >= PW'(2)) begin
                        state_d     = REQ;
                        fetch_req_d = 1'b1;
                    end
                end
                REQ: begin
                    if (pfp_set) begin
                        state_d     = IDLE;
                        fetch_req_d = 1'b0;
                    end else if (fetch_ack) begin
                        state_d     = WAIT;
                        fetch_req_d = 1'b0;
                    end
                end
                WAIT: begin
                    if (fetch_done) begin
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else if (pfp_set) begin
                        discard_d = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    fetch_req_d = 1'b0;
                    discard_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            fetch_req_q <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_req_q <= fetch_req_d;
            discard_q   <= discard_d;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_q        <= '0;
            wr_q        <= '0;
            head_q      <= '0;
            pfp_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            head_q      <= head_d;
            pfp_q       <= pfp_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage resets to 8'hFF so the head bytes read as FF out of reset.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'hFF;
            end
        end else begin
            if (we0) begin
                mem_q[wr_idx0] <= fill_b0;
            end
            if (we1) begin
                mem_q[wr_idx1] <= fill_b1;
            end
        end
    end

endmodule
